// File: rtl/mul_share_pkg.sv
// mul_share_pkg: FSM states and EXEC depth for mul_share_sched
// EXEC depth follows MUL_SHARE_SCHED_PIPE_EN.
package mul_share_pkg;
`ifdef MUL_SHARE_SCHED_PIPE_EN
  localparam int EXEC_CYCLES = 2;
`else
  localparam int EXEC_CYCLES = 1;
`endif
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/mul_share_sched_arbiter.sv
// rr_arbiter: round-robin pick of one requester, searching upward from ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  // Walk from the farthest slot back to ptr so the nearest active request wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = N'(1) << ((int'(ptr) + k) % N);
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/mul_share_sched_mult.sv
// array_mult: unsigned WxW array multiplier; MUL_SHARE_SCHED_PIPE_EN registers the
// partial products before the final sum.
module array_mult #(
  parameter int W = 8
) (
`ifdef MUL_SHARE_SCHED_PIPE_EN
  input  logic           clk,
  input  logic           rst_n,
`endif
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  logic [W-1:0][2*W-1:0] pp_d, pp_s;
  always_comb begin
    for (int i = 0; i < W; i++) pp_d[i] = b[i] ? ({{W{1'b0}}, a} << i) : '0;
  end
`ifdef MUL_SHARE_SCHED_PIPE_EN
  logic [W-1:0][2*W-1:0] pp_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pp_q <= '0;
    else pp_q <= pp_d;
  end
  assign pp_s = pp_q;
`else
  assign pp_s = pp_d;
`endif
  always_comb begin
    p = '0;
    for (int i = 0; i < W; i++) p = p + pp_s[i];
  end
endmodule

// File: rtl/mul_share_sched.sv
// mul_share_sched: one shared multiplier time-multiplexed across N_REQ requesters
// with round-robin grant; MUL_SHARE_SCHED_PIPE_EN adds one EXEC cycle.
module mul_share_sched
  import mul_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W = 8,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0] req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IW-1:0]    rsp_id,
  output logic [2*W-1:0]   rsp_out
);
  state_t state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, own_q, own_d, rsp_id_q, rsp_id_d, g_idx;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2*W-1:0] rsp_out_q, rsp_out_d, prod;
  logic rsp_valid_q, rsp_valid_d;
  logic [N_REQ-1:0] gnt;

  rr_arbiter #(.N(N_REQ)) u_arb (.req(req_valid), .ptr(rr_q), .gnt(gnt), .idx(g_idx));

  array_mult #(.W(W)) u_mul (
`ifdef MUL_SHARE_SCHED_PIPE_EN
    .clk(clk), .rst_n(rst_n),
`endif
    .a(a_q), .b(b_q), .p(prod)
  );

  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    own_d = own_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    rsp_out_d = rsp_out_q;
    rsp_id_d = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: if (|req_valid) begin
        state_d = EXEC;
        a_d = req_a[int'(g_idx)*W +: W];
        b_d = req_b[int'(g_idx)*W +: W];
        own_d = g_idx;
        rr_d = (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
        cnt_d = '0;
      end
      EXEC: if (cnt_q == 2'(EXEC_CYCLES - 1)) begin
        state_d = DONE;
        rsp_out_d = prod;
        rsp_id_d = own_q;
        rsp_valid_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      DONE: if (rsp_ready) begin
        state_d = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= '0;
      own_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      rsp_out_q <= '0;
      rsp_id_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      own_q <= own_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      rsp_out_q <= rsp_out_d;
      rsp_id_q <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Grant strobe is combinational so it marks the sampling cycle itself; reset masks it.
  assign req_ready = (state_q == IDLE && rst_n) ? gnt : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_out = rsp_out_q;
endmodule

// File: tb/tb_mul_share_sched.sv
// tb_mul_share_sched: directed checks of mul_share_sched (W=8 and W=2 instances)
module tb_mul_share_sched;
`ifdef MUL_SHARE_SCHED_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic rsp_valid, rsp_ready;
  logic [1:0] rsp_id;
  logic [15:0] rsp_out;
  logic [3:0] v2, r2;
  logic [7:0] a2, b2;
  logic rv2, rr2;
  logic [1:0] id2;
  logic [3:0] o2;
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  mul_share_sched #(.N_REQ(4), .W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_out(rsp_out)
  );

  mul_share_sched #(.N_REQ(4), .W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_a(a2), .req_b(b2),
    .req_ready(r2), .rsp_valid(rv2), .rsp_ready(rr2),
    .rsp_id(id2), .rsp_out(o2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Single-requester transaction starting at a negedge in IDLE, ending back in IDLE.
  task automatic do_op(input int r, input int a, input int b);
    req_valid = 4'b0001 << r;
    req_a = '0;
    req_b = '0;
    req_a[r*8 +: 8] = 8'(a);
    req_b[r*8 +: 8] = 8'(b);
    rsp_ready = 1'b1;
    #1 chk("op_grant", req_ready, 64'(4'b0001 << r));
    @(negedge clk);
    req_valid = '0;
    chk("op_ready_exec", req_ready, 0);
    chk("op_vld_exec", rsp_valid, 0);
    repeat (LAT - 2) @(negedge clk);
    @(negedge clk);
    chk("op_vld", rsp_valid, 1);
    chk("op_out", rsp_out, 64'(a * b));
    chk("op_id", rsp_id, 64'(r));
    @(negedge clk);
    chk("op_vld_drop", rsp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = 4'hF;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    v2 = '0;
    a2 = '0;
    b2 = '0;
    rr2 = 1'b1;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_out", rsp_out, 0);
    chk("rst_id", rsp_id, 0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(0, 3, 2);
    do_op(0, 255, 255);
    do_op(3, 0, 200);
    do_op(1, 17, 13);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'(i + 1);
      req_b[i*8 +: 8] = 8'd10;
    end
    for (int n = 0; n < 5; n++) begin
      #1 chk("rr_grant", req_ready, 64'(4'b0001 << (n % 4)));
      @(negedge clk);
      repeat (LAT - 1) @(negedge clk);
      chk("rr_vld", rsp_valid, 1);
      chk("rr_id", rsp_id, 64'(n % 4));
      chk("rr_out", rsp_out, 64'((n % 4 + 1) * 10));
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    #1 chk("hold_grant", req_ready, 4'b0010);
    @(negedge clk);
    repeat (LAT - 1) @(negedge clk);
    chk("hold_vld0", rsp_valid, 1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("hold_vld", rsp_valid, 1);
      chk("hold_out", rsp_out, 20);
      chk("hold_id", rsp_id, 1);
      chk("hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_next", req_ready, 4'b0100);
    @(negedge clk);
    chk("exec_ready", req_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("xrst_vld", rsp_valid, 0);
    chk("xrst_out", rsp_out, 0);
    chk("xrst_id", rsp_id, 0);
    chk("xrst_ready", req_ready, 0);
    @(negedge clk);
    chk("xrst_vld2", rsp_valid, 0);
    rst_n = 1'b1;
    #1 chk("xrst_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    chk("xrst_noresp", rsp_valid, 0);
    repeat (LAT - 1) @(negedge clk);
    chk("xrst_vld", rsp_valid, 1);
    chk("xrst_out2", rsp_out, 10);
    chk("xrst_id2", rsp_id, 0);
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        v2 = 4'b0100;
        a2 = 8'(a << 4);
        b2 = 8'(b << 4);
        #1 chk("w2_grant", r2, 4'b0100);
        @(negedge clk);
        v2 = '0;
        repeat (LAT - 1) @(negedge clk);
        chk("w2_vld", rv2, 1);
        chk("w2_out", o2, 64'(a * b));
        chk("w2_id", id2, 2);
        @(negedge clk);
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mul_share_sched.md
MUL_SHARE_SCHED -- requirements
Module: mul_share_sched

Interface
REQ-001 Parameter N_REQ, default 4, is the number of requesters sharing the multiplier; legal range 2..8.
REQ-002 Parameter W, default 8, is the unsigned operand width; the product is 2*W bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  N_REQ  per-requester operand-valid.
REQ-006 req_a  input  N_REQ*W  flattened operand A; requester i occupies bits [i*W +: W].
REQ-007 req_b  input  N_REQ*W  flattened operand B, same packing as req_a.
REQ-008 req_ready  output  N_REQ  one-hot operand-accept strobe.
REQ-009 rsp_valid  output  1  result valid.
REQ-010 rsp_ready  input  1  result consumer ready.
REQ-011 rsp_id  output  $clog2(N_REQ)  index of the requester owning rsp_out.
REQ-012 rsp_out  output  2*W  unsigned product a*b.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC and DONE.
REQ-014 In IDLE with any req_valid set, the block SHALL grant exactly one requester, chosen round-robin starting from rr_ptr; it SHALL assert that requester's req_ready for that cycle only, capture its operands and index, and move to EXEC.
REQ-015 In IDLE with no req_valid set, req_ready SHALL be all-zero and the state SHALL remain IDLE.
REQ-016 After each grant to index g, rr_ptr SHALL become (g+1) mod N_REQ; rr_ptr SHALL wrap from N_REQ-1 to 0.
REQ-017 EXEC SHALL last a fixed number of cycles (see REQ-028/029); the block SHALL then register the product and move to DONE.
REQ-018 In DONE, rsp_valid SHALL be 1, and rsp_out and rsp_id SHALL be held stable until rsp_ready is sampled high.
REQ-019 In DONE with rsp_ready=1, the block SHALL go to IDLE; the next grant SHALL occur no earlier than the following cycle.
REQ-020 req_ready SHALL be zero outside IDLE; at most one operation SHALL be in flight.
REQ-021 The product SHALL be exact: rsp_out = a*b for all 0..2^W-1 operands, with no truncation or overflow.
REQ-022 A requester that deasserts req_valid before it is granted SHALL lose nothing; operands are sampled only in the grant cycle.

Reset
REQ-023 On rst_n low, the state SHALL become IDLE, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_id 0 and rsp_out 0, regardless of the clock.
REQ-024 A reset asserted during EXEC or DONE SHALL discard the in-flight result; no rsp_valid SHALL follow from it.
REQ-025 After rst_n deasserts, the first grant SHALL favour requester 0.

Configuration
REQ-026 The macro MUL_SHARE_SCHED_PIPE_EN SHALL select the EXEC depth.
REQ-027 The macro SHALL only change latency, never results or arbitration order.
REQ-028 Without MUL_SHARE_SCHED_PIPE_EN, EXEC SHALL be 1 cycle, with the multiplier combinational between the operand and result registers; grant to rsp_valid takes 2 cycles.
REQ-029 With MUL_SHARE_SCHED_PIPE_EN, EXEC SHALL be 2 cycles with a register between partial-product and final-sum stages; grant to rsp_valid takes 3 cycles.

Structure
REQ-030 Package mul_share_pkg SHALL hold the state enum (IDLE/EXEC/DONE) and the EXEC_CYCLES constant derived from the macro.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: req vector and pointer; outputs: one-hot grant and index).
REQ-032 The multiplier SHALL be an unsigned array multiplier of width W instantiated inside mul_share_sched.

Verification
REQ-033 Reset, then req_valid=0001 with a0=3, b0=2 -> req_ready=0001 for 1 cycle; rsp_valid=1 with rsp_out=6 and rsp_id=0 after 2 cycles (3 with the macro).
REQ-034 All four requesters valid continuously with rsp_ready=1 -> grants follow the order 0,1,2,3,0; each requester receives exactly one grant per four operations.
REQ-035 W=8, a=255, b=255 -> rsp_out=65025 (0xFE01); a=0, b=200 -> rsp_out=0.
REQ-036 rsp_ready held 0 for 5 cycles in DONE -> rsp_out and rsp_id remain stable, req_ready stays 0, and no new grant occurs.
REQ-037 rst_n pulsed low during EXEC -> all outputs return to 0 immediately, no rsp_valid appears, and the next grant goes to requester 0.
REQ-038 Exhaustive W=2 sweep (all 16 operand pairs) through requester 2 -> each rsp_out equals a*b and rsp_id=2.
